// File: rtl/mmcm_sup_pkg.sv
// Shared types and constants for the MMCM lock supervisor: state encodings,
// retry counter width and a helper for sizing the per-state timer.
package mmcm_sup_pkg;

    typedef logic [2:0] state_t;

    localparam state_t RESET_HOLD = 3'd0;
    localparam state_t WAIT_LOCK  = 3'd1;
    localparam state_t STABILIZE  = 3'd2;
    localparam state_t READY      = 3'd3;
    localparam state_t FAULT      = 3'd4;

    localparam int RETRY_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_reg <= 2'b00;
        end else begin
            ff_reg <= {ff_reg[0], d};
        end
    end

    assign q = ff_reg[1];

endmodule

// File: rtl/mmcm_lock_supervisor.sv
// Sequences MMCM reset, waits for a stable LOCKED, and retries with a bounded budget.
// Optional relock statistics output enabled by defining MMCM_SUPERVISOR_STATS_EN.
module mmcm_lock_supervisor
    import mmcm_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mmcm_locked,
    input  logic               restart,
    output logic               mmcm_reset,
    output logic               ready,
    output logic               fault,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef MMCM_SUPERVISOR_STATS_EN
    ,
    output logic [15:0]        relock_cnt
`endif
);

    localparam int TIMER_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [31:0]        MAX_R        = MAX_RETRIES;

    logic               lock_s;
    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [RETRY_W-1:0] retry_reg, retry_next, retry_inc;
    logic               mmcm_reset_reg, ready_reg, fault_reg;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mmcm_locked),
        .q     (lock_s)
    );

    assign retry_inc = (retry_reg == {RETRY_W{1'b1}}) ? retry_reg : retry_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        if (restart) begin
            state_next = RESET_HOLD;
            timer_next = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                RESET_HOLD: begin
                    if (timer_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (lock_s) begin
                        state_next = STABILIZE;
                        timer_next = '0;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        retry_next = retry_inc;
                        timer_next = '0;
                        if (MAX_R != 32'd0 && {{(32-RETRY_W){1'b0}}, retry_inc} == MAX_R) begin
                            state_next = FAULT;
                        end else begin
                            state_next = RESET_HOLD;
                        end
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end else if (timer_reg == STABLE_LAST) begin
                        state_next = READY;
                        timer_next = '0;
                        retry_next = '0;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                READY: begin
                    if (!lock_s) begin
                        state_next = RESET_HOLD;
                        timer_next = '0;
                    end
                end
                FAULT: begin
                    timer_next = '0;
                end
                default: begin
                    state_next = RESET_HOLD;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RESET_HOLD;
            timer_reg      <= '0;
            retry_reg      <= '0;
            mmcm_reset_reg <= 1'b1;
            ready_reg      <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            mmcm_reset_reg <= (state_next == RESET_HOLD) || (state_next == FAULT);
            ready_reg      <= (state_next == READY);
            fault_reg      <= (state_next == FAULT);
        end
    end

    assign mmcm_reset = mmcm_reset_reg;
    assign ready      = ready_reg;
    assign fault      = fault_reg;
    assign state      = state_reg;
    assign retry_cnt  = retry_reg;

`ifdef MMCM_SUPERVISOR_STATS_EN
    logic        lock_lost;
    logic [15:0] relock_reg;

    assign lock_lost = (state_reg == READY) && !lock_s && !restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            relock_reg <= '0;
        end else if (lock_lost && relock_reg != 16'hFFFF) begin
            relock_reg <= relock_reg + 1'b1;
        end
    end

    assign relock_cnt = relock_reg;
`endif

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Scoreboard bench: a cycle model pushes expected outputs each cycle, a monitor pops and compares.
module tb_mmcm_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_ST  = 8;
    localparam int P_MR  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       mmcm_locked;
    logic       restart;
    logic       mmcm_reset;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [7:0] retry_cnt;
    logic [15:0] relock_cnt;

    always #5 clk = ~clk;

    mmcm_lock_supervisor #(
        .RST_CYCLES    (P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .STABLE_CYCLES (P_ST),
        .MAX_RETRIES   (P_MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mmcm_locked (mmcm_locked),
        .restart     (restart),
        .mmcm_reset  (mmcm_reset),
        .ready       (ready),
        .fault       (fault),
        .state       (state),
        .retry_cnt   (retry_cnt)
`ifdef MMCM_SUPERVISOR_STATS_EN
        ,
        .relock_cnt  (relock_cnt)
`endif
    );

`ifndef MMCM_SUPERVISOR_STATS_EN
    assign relock_cnt = 16'd0;
`endif

    typedef struct packed {
        logic [2:0]  st;
        logic        mr;
        logic        rdy;
        logic        flt;
        logic [7:0]  rc;
        logic [15:0] rl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    // Reference model state
    int m_st = 0, m_cnt = 0, m_rc = 0, m_rl = 0;
    bit m_s1 = 0, m_s2 = 0;

    task automatic step();
        bit   seen;
        exp_t e;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_rc = 0; m_rl = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = mmcm_locked;
            if (restart) begin
                m_st = 0; m_cnt = 0; m_rc = 0;
            end else if (m_st == 0) begin
                if (m_cnt == P_RST - 1) begin m_st = 1; m_cnt = 0; end
                else m_cnt++;
            end else if (m_st == 1) begin
                if (seen) begin m_st = 2; m_cnt = 0; end
                else if (m_cnt == P_TO - 1) begin
                    if (m_rc < 255) m_rc++;
                    m_st = (P_MR != 0 && m_rc == P_MR) ? 4 : 0;
                    m_cnt = 0;
                end else m_cnt++;
            end else if (m_st == 2) begin
                if (!seen) begin m_st = 1; m_cnt = 0; end
                else if (m_cnt == P_ST - 1) begin m_st = 3; m_cnt = 0; m_rc = 0; end
                else m_cnt++;
            end else if (m_st == 3) begin
                if (!seen) begin
                    m_st = 0; m_cnt = 0;
                    if (m_rl < 65535) m_rl++;
                end
            end
        end
        e.st  = 3'(m_st);
        e.mr  = (m_st == 0 || m_st == 4);
        e.rdy = (m_st == 3);
        e.flt = (m_st == 4);
        e.rc  = 8'(m_rc);
`ifdef MMCM_SUPERVISOR_STATS_EN
        e.rl  = 16'(m_rl);
`else
        e.rl  = 16'd0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            compared++;
            if ({state, mmcm_reset, ready, fault, retry_cnt, relock_cnt} !== mon_e) begin
                mismatched++;
                $display("FAIL sb_cycle cyc=%0d got st=%0d mr=%b rdy=%b flt=%b rc=%0d rl=%0d exp st=%0d mr=%b rdy=%b flt=%b rc=%0d rl=%0d",
                         cyc, state, mmcm_reset, ready, fault, retry_cnt, relock_cnt,
                         mon_e.st, mon_e.mr, mon_e.rdy, mon_e.flt, mon_e.rc, mon_e.rl);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; restart = 1'b0; mmcm_locked = 1'b0;
        repeat (3) step();
        compared++;
        if ({state, mmcm_reset, ready, fault, retry_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            mismatched++;
            $display("FAIL reset_state got st=%0d mr=%b rdy=%b flt=%b rc=%0d exp st=0 mr=1 rdy=0 flt=0 rc=0",
                     state, mmcm_reset, ready, fault, retry_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock_up();
        int hi = 0;
        int n = 0;
        repeat (10) begin
            if (mmcm_reset) hi++;
            step();
        end
        compared++;
        if (hi != P_RST) begin
            mismatched++;
            $display("FAIL initial_hold got=%0d cycles exp=%0d", hi, P_RST);
        end
        mmcm_locked = 1'b1;
        while (!ready && n < 40) begin step(); n++; end
        compared++;
        if (n != 2 + P_ST + 1 || retry_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL lock_up_latency got=%0d rc=%0d exp=%0d rc=0", n, retry_cnt, 2 + P_ST + 1);
        end
    endtask

    task automatic test_relock();
        int n = 0;
        int hi = 0;
        mmcm_locked = 1'b0;
        while (ready && n < 10) begin step(); n++; end
        compared++;
        if (ready !== 1'b0 || n > 3) begin
            mismatched++;
            $display("FAIL relock_drop got=%0d cycles rdy=%b exp<=3 rdy=0", n, ready);
        end
        while (mmcm_reset && hi < 20) begin step(); hi++; end
        compared++;
        if (hi != P_RST) begin
            mismatched++;
            $display("FAIL relock_hold got=%0d exp=%0d", hi, P_RST);
        end
`ifdef MMCM_SUPERVISOR_STATS_EN
        compared++;
        if (relock_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL relock_cnt got=%0d exp=1", relock_cnt);
        end
`endif
        mmcm_locked = 1'b1;
        n = 0;
        while (!ready && n < 60) begin step(); n++; end
        compared++;
        if (ready !== 1'b1) begin
            mismatched++;
            $display("FAIL relock_ready got=%b exp=1", ready);
        end
    endtask

    task automatic test_timeout();
        mmcm_locked = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        for (int n = 1; n <= 3 * (P_RST + P_TO); n++) begin
            step();
            if (n == P_RST + P_TO - 1 || n == P_RST + P_TO || n == 2 * (P_RST + P_TO)) begin
                compared++;
                if (retry_cnt !== 8'(n / (P_RST + P_TO)) || state !== 3'd0 && n != P_RST + P_TO - 1) begin
                    mismatched++;
                    $display("FAIL timeout_retry n=%0d got rc=%0d st=%0d exp rc=%0d",
                             n, retry_cnt, state, n / (P_RST + P_TO));
                end
            end
        end
        compared++;
        if ({state, fault, mmcm_reset, ready, retry_cnt} !== {3'd4, 1'b1, 1'b1, 1'b0, 8'd3}) begin
            mismatched++;
            $display("FAIL fault_entry got st=%0d flt=%b mr=%b rdy=%b rc=%0d exp st=4 flt=1 mr=1 rdy=0 rc=3",
                     state, fault, mmcm_reset, ready, retry_cnt);
        end
        repeat (10) step();
        compared++;
        if (state !== 3'd4 || fault !== 1'b1 || mmcm_reset !== 1'b1) begin
            mismatched++;
            $display("FAIL fault_sticky got st=%0d flt=%b mr=%b exp st=4 flt=1 mr=1", state, fault, mmcm_reset);
        end
        restart = 1'b1; step(); restart = 1'b0;
        compared++;
        if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL fault_restart got st=%0d flt=%b rc=%0d exp st=0 flt=0 rc=0", state, fault, retry_cnt);
        end
    endtask

    task automatic test_glitch();
        int n = 0;
        mmcm_locked = 1'b1;
        while (state !== 3'd2 && n < 20) begin step(); n++; end
        repeat (5) step();
        mmcm_locked = 1'b0; step(); mmcm_locked = 1'b1;
        n = 0;
        while (state === 3'd2 && n < 10) begin step(); n++; end
        compared++;
        if (state !== 3'd1 || retry_cnt !== 8'd0 || ready !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_return got st=%0d rc=%0d rdy=%b exp st=1 rc=0 rdy=0", state, retry_cnt, ready);
        end
        n = 0;
        while (!ready && n < 30) begin step(); n++; end
        compared++;
        if (n != P_ST + 1) begin
            mismatched++;
            $display("FAIL glitch_delay got=%0d exp=%0d", n, P_ST + 1);
        end
    endtask

    task automatic test_restart_timeout();
        int hi = 0;
        mmcm_locked = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        repeat (P_RST + P_TO - 1) step();
        compared++;
        if (state !== 3'd1) begin
            mismatched++;
            $display("FAIL pre_timeout got st=%0d exp st=1", state);
        end
        restart = 1'b1; step(); restart = 1'b0;
        compared++;
        if (state !== 3'd0 || retry_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL restart_vs_timeout got st=%0d rc=%0d exp st=0 rc=0", state, retry_cnt);
        end
        while (mmcm_reset && hi < 20) begin step(); hi++; end
        compared++;
        if (hi != P_RST) begin
            mismatched++;
            $display("FAIL restart_hold got=%0d exp=%0d", hi, P_RST);
        end
        restart = 1'b1; step(); restart = 1'b0;
        repeat (2) step();
        reset = 1'b1; step(); reset = 1'b0;
        compared++;
        if (state !== 3'd0 || mmcm_reset !== 1'b1 || retry_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL midhold_reset got st=%0d mr=%b rc=%0d exp st=0 mr=1 rc=0", state, mmcm_reset, retry_cnt);
        end
        hi = 0;
        while (mmcm_reset && hi < 20) begin step(); hi++; end
        compared++;
        if (hi != P_RST) begin
            mismatched++;
            $display("FAIL midhold_full_hold got=%0d exp=%0d", hi, P_RST);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        mmcm_locked = 1'b1;
        restart = 1'b1; step(); step(); restart = 1'b0;
        while (!ready && n < 60) begin step(); n++; end
        compared++;
        if (ready !== 1'b1 || retry_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL back_to_back got rdy=%b rc=%0d exp rdy=1 rc=0", ready, retry_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_relock();
        test_timeout();
        test_glitch();
        test_restart_timeout();
        test_back_to_back();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
